// File: rtl/fp_to_linear_pkg.sv
// ---------------------------------------------------------------------------
// fp_to_linear_pkg
//
// Shared definitions for the 8-bit float {S, E[2:0], F[3:0]} to 12-bit
// two's-complement linear decoder.
//
//   EXP_W   : exponent width
//   MAN_W   : significand width
//   OUT_W   : linear output width
//   MAX_MAG : largest decodable magnitude, ((2^MAN_W)-1) << ((2^EXP_W)-1)
//   state_t : decoder FSM states
// ---------------------------------------------------------------------------
package fp_to_linear_pkg;

    localparam int EXP_W = 3;
    localparam int MAN_W = 4;
    localparam int OUT_W = 12;

    // 15 << 7 = 1920. Fits in OUT_W-1 magnitude bits, so neither the shift
    // nor the negation can overflow and -2048 is never produced.
    localparam int MAX_MAG = ((1 << MAN_W) - 1) << ((1 << EXP_W) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : fp_to_linear_pkg

// File: rtl/fp_to_linear_magnitude_to_twos_complement.sv
// ---------------------------------------------------------------------------
// magnitude_to_twos_complement
//
// Combinational conditional negate: turns an unsigned magnitude plus a sign
// flag into a W-bit two's-complement value (wrap arithmetic).
//
// Ports:
//   i_sign  : 1 = negate the magnitude
//   i_mag   : unsigned magnitude, W bits
//   o_value : two's-complement result, W bits
// ---------------------------------------------------------------------------
module magnitude_to_twos_complement #(
    parameter int W = 12
) (
    input  logic         i_sign,
    input  logic [W-1:0] i_mag,
    output logic [W-1:0] o_value
);

    logic [W-1:0] w_one;
    logic [W-1:0] w_negated;

    assign w_one     = {{(W-1){1'b0}}, 1'b1};
    // A zero magnitude negates back to zero, so a negative zero input
    // collapses to plain 0.
    assign w_negated = ~i_mag + w_one;
    assign o_value   = i_sign ? w_negated : i_mag;

endmodule : magnitude_to_twos_complement

// File: rtl/fp_to_linear.sv
// ---------------------------------------------------------------------------
// fp_to_linear
//
// Iterative decoder from the 8-bit float {S, E, F} to OUT_W-bit two's-
// complement linear data: D = (-1)^S * F * 2^E. The significand is loaded
// into an accumulator and shifted left one bit per clock until the exponent
// counter reaches zero, then the sign is applied once on the way to DONE.
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : S/E/F valid this cycle
//   in_ready  : decoder idle and able to accept a new input
//   S, E, F   : sign, exponent, significand
//   out_valid : D holds a completed result
//   out_ready : downstream accepts D
//   D         : two's-complement linear result (held after the handshake)
//
// Timing: acceptance edge to first out_valid cycle is E+1 clocks; with
// out_ready tied high one conversion completes every E+3 clocks.
// ---------------------------------------------------------------------------
module fp_to_linear #(
    parameter int EXP_W = fp_to_linear_pkg::EXP_W,
    parameter int MAN_W = fp_to_linear_pkg::MAN_W,
    parameter int OUT_W = fp_to_linear_pkg::OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             S,
    input  logic [EXP_W-1:0] E,
    input  logic [MAN_W-1:0] F,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] D
);

    import fp_to_linear_pkg::state_t;
    import fp_to_linear_pkg::IDLE;
    import fp_to_linear_pkg::SHIFT;
    import fp_to_linear_pkg::DONE;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [OUT_W-1:0]   r_acc;
    logic [EXP_W-1:0]   r_cnt;
    logic               r_sign;
    logic [OUT_W-1:0]   r_d;

    state_t             w_state_next;
    logic [OUT_W-1:0]   w_acc_next;
    logic [EXP_W-1:0]   w_cnt_next;
    logic               w_sign_next;
    logic [OUT_W-1:0]   w_d_next;

    logic [OUT_W-1:0]   w_f_ext;
    logic [OUT_W-1:0]   w_acc_shl;
    logic [EXP_W-1:0]   w_cnt_dec;
    logic [OUT_W-1:0]   w_signed_value;

    assign w_f_ext   = {{(OUT_W-MAN_W){1'b0}}, F};
    assign w_acc_shl = {r_acc[OUT_W-2:0], 1'b0};
    assign w_cnt_dec = r_cnt - {{(EXP_W-1){1'b0}}, 1'b1};

    // Sign is applied to the fully shifted magnitude in the SHIFT->DONE step.
    magnitude_to_twos_complement #(
        .W (OUT_W)
    ) u_negate (
        .i_sign  (r_sign),
        .i_mag   (r_acc),
        .o_value (w_signed_value)
    );

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_sign_next  = r_sign;
        w_d_next     = r_d;

        case (r_state)
            IDLE: begin
                // Inputs are captured only here; anything presented while
                // busy is dropped, there is no skid buffer.
                if (in_valid) begin
                    w_acc_next   = w_f_ext;
                    w_cnt_next   = E;
                    w_sign_next  = S;
                    w_state_next = SHIFT;
                end
            end

            SHIFT: begin
                if (r_cnt != '0) begin
                    w_acc_next = w_acc_shl;
                    w_cnt_next = w_cnt_dec;
                end else begin
                    w_d_next     = w_signed_value;
                    w_state_next = DONE;
                end
            end

            DONE: begin
                // Always pass through IDLE, so an in_valid coincident with
                // the output handshake is taken one cycle later.
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_d     <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_sign  <= w_sign_next;
            r_d     <= w_d_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The state register already sits in IDLE during reset; gating with
    // rst_n keeps upstream from seeing a ready while reset is held.
    assign in_ready  = rst_n && (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign D         = r_d;

endmodule : fp_to_linear

// File: doc/fp_to_linear.md
Name: fp_to_linear

Overview:
- Iterative decoder from the 8-bit floating-point format {S, E[2:0], F[3:0]} back to 12-bit two's-complement linear data.
- Value = (-1)^S * F * 2^E.
- Reverse path of the linear-to-floating-point converter. Feeds downstream consumers that need linear samples.
- Uses a valid/ready handshake on both sides and a shift-per-cycle datapath.

Parameters:
- EXP_W, 3, exponent width.
- MAN_W, 4, significand width.
- OUT_W, 12, linear output width. Must satisfy MAN_W + 2^EXP_W - 1 <= OUT_W - 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  S/E/F are valid this cycle.
- in_ready  output  1  block can accept a new input.
- S  input  1  sign bit (1 = negative).
- E  input  EXP_W  exponent.
- F  input  MAN_W  significand.
- out_valid  output  1  D holds a completed result.
- out_ready  input  1  downstream accepts D.
- D  output  OUT_W  two's-complement linear result.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; acc, cnt, sign_r cleared.
  - D=0, out_valid=0.
  - in_ready forced 0 while rst_n low.
  - Takes effect immediately, including mid-conversion. The in-flight conversion is discarded, not resumed.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at the rising edge: acc <= zero-extended F, cnt <= E, sign_r <= S, go to SHIFT.
  - Inputs are sampled only at acceptance; later changes are ignored.
- SHIFT:
  - in_ready=0.
  - If cnt!=0: acc <= acc<<1, cnt <= cnt-1.
  - If cnt==0: D <= sign_r ? (~acc+1) : acc (OUT_W-bit wrap arithmetic), go to DONE.
- DONE:
  - out_valid=1; D held stable; in_ready=0.
  - On out_ready=1: go to IDLE and deassert out_valid next cycle.
  - D keeps its last value after leaving DONE.
- Latency: acceptance edge to first cycle with out_valid=1 is E+1 clock cycles (1 for E=0, 8 for E=7).
- Throughput: at most one conversion per E+3 cycles, with out_ready tied high.
- Width rules:
  - Maximum magnitude is 15<<7 = 1920, so no overflow ever occurs.
  - Negation never produces -2048.
- Negative zero: S=1, F=0 yields D=0. There is no distinct -0.
- Denormal-style inputs (F<8 with E>0) are legal and decode exactly as F<<E. No normalisation check.
- Backpressure: out_ready low holds DONE indefinitely. in_valid during SHIFT/DONE is ignored, with no buffering.
- Single-cycle handshake: in DONE with out_ready=1, a same-cycle in_valid is NOT accepted. It is accepted in the following IDLE cycle.

Decomposition:
- Shared package holds:
  - EXP_W, MAN_W, OUT_W constants.
  - The FSM state enum {IDLE, SHIFT, DONE}.
  - The max-magnitude constant 1920.
- One sub-module: magnitude_to_twos_complement. Combinational conditional negate (sign, magnitude -> OUT_W two's complement), instantiated once on the SHIFT->DONE path.

Test Plan:
- Zero input. S=0, E=0, F=0 accepted -> out_valid asserts 1 cycle later, D=12'h000.
- Max positive. S=0, E=7, F=15 -> out_valid after exactly 8 cycles, D=12'h780 (1920).
- Max negative. S=1, E=7, F=15 -> D=12'h880 (-1920). A repeat with S=1, E=0, F=0 -> D=12'h000.
- Backpressure. S=1, E=3, F=9 with out_ready held low 5 cycles -> D=12'hFB8 (-72) stable throughout. in_ready=0, and an in_valid pulse of S=0, E=1, F=1 is ignored. Release out_ready -> IDLE next cycle.
- Back-to-back. Stream E=2,F=5 then E=5,F=12 with out_ready=1 -> D=20 then 384, each with the specified latency, and no input lost while in_valid is held.
- Reset mid-conversion. Assert rst_n=0 during SHIFT of E=6, F=8 -> out_valid=0 and D=0 immediately. After release, S=0, E=1, F=3 -> D=6.
